// File: rtl/int_ctrl_pkg.sv
// Shared types and sizing for the interrupt controller.
package int_ctrl_pkg;
  localparam int INT_VEC_W = 3;
  localparam int MAX_IRQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;
endpackage

// File: rtl/int_ctrl_prio_enc8.sv
// Eight-input priority encoder; the lowest set index wins.
module prio_enc8
  import int_ctrl_pkg::*;
(
  input  logic [MAX_IRQ-1:0]   req,
  output logic [INT_VEC_W-1:0] idx,
  output logic                 vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Walk downward so the lowest set index is the last one written.
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = INT_VEC_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered prioritised interrupt controller with mask, pending and in-service registers.
// Build option INT_CTRL_NEST_EN lets a higher-priority line interrupt a handler in service.
//
// state | meaning
// IDLE  | nothing in service, waiting for an eligible pending line
// REQ   | int_req raised with int_vec frozen, waiting for int_clear
// SVC   | at least one line in service, waiting for iret_op
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 int_clear,
  input  logic                 iret_op,
  input  logic                 mask_wr,
  input  logic [NUM_IRQ-1:0]   mask_data,
  output logic                 int_req,
  output logic [INT_VEC_W-1:0] int_vec,
  output logic [NUM_IRQ-1:0]   pending,
  output logic [NUM_IRQ-1:0]   in_service
);
  localparam logic [NUM_IRQ-1:0] ONE_HOT0 = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  state_t               state;
  logic [NUM_IRQ-1:0]   irq_d;
  logic [NUM_IRQ-1:0]   mask;
  logic                 primed;
  logic [NUM_IRQ-1:0]   irq_edge;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   ack_set;
  logic [NUM_IRQ-1:0]   eoi_clr;
  logic [NUM_IRQ-1:0]   isv_next;
  logic [MAX_IRQ-1:0]   elig8;
  logic [MAX_IRQ-1:0]   isv8;
  logic [INT_VEC_W-1:0] win_idx;
  logic [INT_VEC_W-1:0] isv_idx;
  logic                 win_vld;
  logic                 isv_vld;
  logic                 nest_req;

  // The first clock after reset only loads irq_d, so lines held high through reset raise nothing.
  assign irq_edge = primed ? (irq & ~irq_d) : '0;
  assign eligible = pending & ~mask;
  assign elig8    = MAX_IRQ'(eligible);
  assign isv8     = MAX_IRQ'(in_service);

  prio_enc8 u_win (
    .req (elig8),
    .idx (win_idx),
    .vld (win_vld)
  );

  prio_enc8 u_isv (
    .req (isv8),
    .idx (isv_idx),
    .vld (isv_vld)
  );

  // EOI retires the lowest bit that was in service before this cycle's acknowledge.
  always_comb begin
    ack_set = '0;
    eoi_clr = '0;
    if (state == REQ && int_clear) ack_set = ONE_HOT0 << int_vec;
    if (iret_op && isv_vld) eoi_clr = ONE_HOT0 << isv_idx;
    isv_next = (in_service | ack_set) & ~eoi_clr;
  end

`ifdef INT_CTRL_NEST_EN
  assign nest_req = win_vld && isv_vld && (win_idx < isv_idx);
`else
  assign nest_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d      <= '0;
      primed     <= 1'b0;
      mask       <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      irq_d      <= irq;
      primed     <= 1'b1;
      if (mask_wr) mask <= mask_data;
      pending    <= (pending & ~ack_set) | irq_edge;
      in_service <= isv_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_vec <= win_idx;
          end
        end
        REQ: begin
          if (int_clear) begin
            int_req <= 1'b0;
            state   <= (isv_next != '0) ? SVC : IDLE;
          end
        end
        SVC: begin
          if (isv_next == '0) begin
            state <= IDLE;
          end else if (!iret_op && nest_req) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_vec <= win_idx;
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the controller.
module tb_int_ctrl;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq = '0;
  logic       int_clear = 1'b0;
  logic       iret_op = 1'b0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = '0;
  logic       int_req;
  logic [2:0] int_vec;
  logic [7:0] pending;
  logic [7:0] in_service;

  int n_chk = 0;
  int n_fail = 0;

  // Model: "requesting" flag plus register images; idle vs. servicing follows from m_isv.
  bit       m_int;
  int       m_vec;
  bit [7:0] m_pend, m_isv, m_mask, m_prev;
  bit       m_primed;

  int_ctrl #(.NUM_IRQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .int_clear  (int_clear),
    .iret_op    (iret_op),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int lowest(bit [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  task automatic model_reset();
    m_int = 0; m_vec = 0; m_pend = 0; m_isv = 0; m_mask = 0; m_prev = 0; m_primed = 0;
  endtask

  task automatic model_step();
    bit [7:0] edges, ack, eoi;
    int win, low_isv;
    edges   = m_primed ? (irq & ~m_prev) : 8'h00;
    win     = lowest(m_pend & ~m_mask);
    low_isv = lowest(m_isv);
    ack = 0;
    eoi = 0;
    if (m_int && int_clear) ack[m_vec] = 1'b1;
    if (iret_op && m_isv != 0) eoi[low_isv] = 1'b1;
    if (m_int) begin
      if (int_clear) m_int = 0;
    end else if (m_isv == 0) begin
      if (win < N) begin m_int = 1; m_vec = win; end
    end else if (!iret_op) begin
`ifdef INT_CTRL_NEST_EN
      if (win < low_isv) begin m_int = 1; m_vec = win; end
`endif
    end
    m_pend = (m_pend & ~ack) | edges;
    m_isv  = (m_isv | ack) & ~eoi;
    if (mask_wr) m_mask = mask_data;
    m_prev   = irq;
    m_primed = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("int", int_req, m_int);
    chk("int_vec", int_vec, m_vec);
    chk("pending", pending, m_pend);
    chk("in_service", in_service, m_isv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq = '0; int_clear = 0; iret_op = 0; mask_wr = 0; mask_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve(int v);
    int n = 0;
    while (!int_req && n < 8) begin tick(); n++; end
    chk("serve_int", int_req, 1);
    chk("serve_vec", int_vec, v);
    int_clear = 1; tick(); int_clear = 0;
    chk("serve_isv_bit", in_service[v], 1);
    iret_op = 1; tick(); iret_op = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_int", int_req, 0);
    chk("rst_vec", int_vec, 0);
    chk("rst_pending", pending, 0);
    chk("rst_isv", in_service, 0);
    tick(); tick();

    // Single line: two-clock latency, ack, iret.
    irq = 8'h08; tick(); irq = 0;
    chk("l3_pend", pending, 8'h08);
    chk("l3_noint", int_req, 0);
    tick();
    chk("l3_int", int_req, 1);
    chk("l3_vec", int_vec, 3);
    int_clear = 1; tick(); int_clear = 0;
    chk("l3_ack_int", int_req, 0);
    chk("l3_ack_pend", pending, 0);
    chk("l3_ack_isv", in_service, 8'h08);
    iret_op = 1; tick(); iret_op = 0;
    chk("l3_eoi_isv", in_service, 0);
    tick();
    chk("l3_idle", int_req, 0);

    // Several simultaneous edges served in index order.
    irq = 8'hA4; tick(); irq = 0;
    chk("multi_pend", pending, 8'hA4);
    serve(2); serve(5); serve(7);
    chk("multi_done", pending, 0);

    // Higher-priority edge while requesting does not move the vector.
    irq = 8'h20; tick(); irq = 0; tick();
    chk("hold_vec5", int_vec, 5);
    irq = 8'h02; tick(); irq = 0; tick();
    chk("hold_int", int_req, 1);
    chk("hold_vec", int_vec, 5);
    chk("hold_pend1", pending[1], 1);
    int_clear = 1; tick(); int_clear = 0;
    chk("hold_ack_pend", pending, 8'h02);
    chk("hold_ack_isv", in_service, 8'h20);
    iret_op = 1; tick(); iret_op = 0;
    serve(1);

    // Masked line accumulates pending and is released by a mask write.
    mask_wr = 1; mask_data = 8'h01; tick(); mask_wr = 0;
    irq = 8'h01; tick(); irq = 0; tick(); tick();
    chk("mask_noint", int_req, 0);
    chk("mask_pend", pending, 8'h01);
    mask_wr = 1; mask_data = 8'h00; tick(); mask_wr = 0;
    chk("unmask_wait", int_req, 0);
    tick();
    chk("unmask_int", int_req, 1);
    chk("unmask_vec", int_vec, 0);
    serve(0);

    // Higher-priority line arriving while line 4 is in service.
    irq = 8'h10; tick(); irq = 0; tick();
    chk("nest_vec4", int_vec, 4);
    int_clear = 1; tick(); int_clear = 0;
    chk("nest_isv4", in_service, 8'h10);
    irq = 8'h02; tick(); irq = 0; tick();
`ifdef INT_CTRL_NEST_EN
    chk("nest_int", int_req, 1);
    chk("nest_vec", int_vec, 1);
    int_clear = 1; tick(); int_clear = 0;
    chk("nest_isv12", in_service, 8'h12);
    iret_op = 1; tick(); iret_op = 0;
    chk("nest_isv10", in_service, 8'h10);
    iret_op = 1; tick(); iret_op = 0;
    chk("nest_isv0", in_service, 0);
    tick();
`else
    repeat (3) tick();
    chk("nonest_noint", int_req, 0);
    iret_op = 1; tick(); iret_op = 0;
    chk("nonest_isv0", in_service, 0);
    tick();
    chk("nonest_int", int_req, 1);
    chk("nonest_vec", int_vec, 1);
    serve(1);
`endif

    // Asynchronous reset in the middle of a request.
    irq = 8'h04; tick(); irq = 0; tick();
    chk("arst_pre_int", int_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_int", int_req, 0);
    chk("arst_pend", pending, 0);
    chk("arst_isv", in_service, 0);
    model_reset();
    irq = 8'h02;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("held_noedge_pend", pending, 0);
    chk("held_noedge_int", int_req, 0);
    irq = 0; tick();
    irq = 8'h02; tick();
    chk("rearm_pend", pending, 8'h02);
    irq = 0;
    serve(1);

    // Randomized traffic against the model.
    do_reset();
    tick(); tick();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ (8'($urandom) & 8'($urandom));
      int_clear = m_int ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      iret_op   = ($urandom_range(0, 5) == 0);
      mask_wr   = ($urandom_range(0, 31) == 0);
      mask_data = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
